// File: rtl/xor_pkg.sv
// Shared constants and types for the xor_oper result accumulator.
package xor_pkg;

  localparam int DW_DEF        = 4;
  localparam int N_SAMPLES_DEF = 4;
  localparam int DRPW_DEF      = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Bits needed to hold the popcount of a w-bit word.
  function automatic int pop_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/xor_result_accum_pop_count.sv
// Combinational population count of one DW-bit word.
module pop_count
  import xor_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int PW = pop_w(DW)
) (
  input  logic [DW-1:0] din,
  output logic [PW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DW; i++) cnt = cnt + PW'(din[i]);
  end

endmodule

// File: rtl/xor_result_accum.sv
// Accumulates N_SAMPLES xor_oper results into a parity/popcount/count summary
// and holds it on a valid/ready port, counting samples lost while holding.
module xor_result_accum
  import xor_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int DRPW      = DRPW_DEF,
  parameter int CNTW      = $clog2(N_SAMPLES + 1),
  parameter int POPW      = $clog2(DW * N_SAMPLES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   co,
  input  logic            co_vld,
  input  logic            flush,
  output logic            in_rdy,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic [DW-1:0]   res_par,
  output logic [POPW-1:0] res_pop,
  output logic [CNTW-1:0] res_cnt,
  output logic [DRPW-1:0] drop_cnt
);

  localparam int PCW = pop_w(DW);

  state_e            state_q;
  logic [DW-1:0]     acc_par_q, acc_par_d;
  logic [POPW-1:0]   acc_pop_q, acc_pop_d;
  logic [CNTW-1:0]   acc_cnt_q, acc_cnt_d;
  logic              in_rdy_q, res_vld_q;
  logic [DW-1:0]     res_par_q;
  logic [POPW-1:0]   res_pop_q;
  logic [CNTW-1:0]   res_cnt_q;
  logic [DRPW-1:0]   drop_q;
  logic [PCW-1:0]    co_pop;
  logic              close_d;

  pop_count #(.DW(DW), .PW(PCW)) u_pop (
    .din (co),
    .cnt (co_pop)
  );

  // Accumulator values including this cycle's sample (if any).
  always_comb begin
    acc_par_d = acc_par_q;
    acc_pop_d = acc_pop_q;
    acc_cnt_d = acc_cnt_q;
    if (co_vld) begin
      acc_par_d = acc_par_q ^ co;
      acc_pop_d = acc_pop_q + POPW'(co_pop);
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
    // A flush with nothing pending and no sample this cycle is a no-op.
    close_d = (co_vld && (acc_cnt_d == CNTW'(N_SAMPLES))) ||
              (flush && (co_vld || (acc_cnt_q != '0)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_par_q <= '0;
      acc_pop_q <= '0;
      acc_cnt_q <= '0;
      in_rdy_q  <= 1'b1;
      res_vld_q <= 1'b0;
      res_par_q <= '0;
      res_pop_q <= '0;
      res_cnt_q <= '0;
      drop_q    <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          acc_par_q <= acc_par_d;
          acc_pop_q <= acc_pop_d;
          acc_cnt_q <= acc_cnt_d;
          if (close_d) begin
            state_q   <= HOLD;
            in_rdy_q  <= 1'b0;
            res_vld_q <= 1'b1;
            res_par_q <= acc_par_d;
            res_pop_q <= acc_pop_d;
            res_cnt_q <= acc_cnt_d;
          end
        end
        HOLD: begin
          // Samples arriving while held are lost, even in the handshake cycle.
          if (co_vld && (drop_q != '1)) drop_q <= drop_q + 1'b1;
          if (res_rdy) begin
            state_q   <= ACCUM;
            in_rdy_q  <= 1'b1;
            res_vld_q <= 1'b0;
            acc_par_q <= '0;
            acc_pop_q <= '0;
            acc_cnt_q <= '0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_rdy   = in_rdy_q;
  assign res_vld  = res_vld_q;
  assign res_par  = res_par_q;
  assign res_pop  = res_pop_q;
  assign res_cnt  = res_cnt_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_xor_result_accum.sv
// Scoreboard bench: expected summaries queued at stimulus time, popped on handshake.
module tb_xor_result_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] co;
  logic       co_vld, flush, res_rdy;

  logic       in_rdy0, res_vld0, in_rdy1, res_vld1;
  logic [3:0] res_par0, res_par1;
  logic [4:0] res_pop0, res_pop1;
  logic [2:0] res_cnt0, res_cnt1;
  logic [7:0] drop0;
  logic [1:0] drop1;

  typedef struct packed {
    logic [3:0] par;
    logic [4:0] pop;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  xor_result_accum u0 (
    .clk(clk), .rst(rst), .co(co), .co_vld(co_vld), .flush(flush),
    .in_rdy(in_rdy0), .res_vld(res_vld0), .res_rdy(res_rdy),
    .res_par(res_par0), .res_pop(res_pop0), .res_cnt(res_cnt0), .drop_cnt(drop0)
  );

  xor_result_accum #(.DRPW(2)) u1 (
    .clk(clk), .rst(rst), .co(co), .co_vld(co_vld), .flush(flush),
    .in_rdy(in_rdy1), .res_vld(res_vld1), .res_rdy(res_rdy),
    .res_par(res_par1), .res_pop(res_pop1), .res_cnt(res_cnt1), .drop_cnt(drop1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [3:0] v, input logic fl);
    co = v; co_vld = 1'b1; flush = fl;
    step();
    co_vld = 1'b0; flush = 1'b0;
  endtask

  // Monitor: every accepted summary must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && res_vld0 && res_rdy) begin
      if (exp_q.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL mon_unexpected: summary par=%0h with empty queue", res_par0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_par", 32'(res_par0), 32'(e.par));
        chk("mon_pop", 32'(res_pop0), 32'(e.pop));
        chk("mon_cnt", 32'(res_cnt0), 32'(e.cnt));
        chk("mon_par_d2", 32'(res_par1), 32'(e.par));
        chk("mon_vld_d2", 32'(res_vld1), 32'd1);
      end
    end
  end

  task automatic handshake();
    res_rdy = 1'b1;
    step();
    res_rdy = 1'b0;
    chk("hs_vld", 32'(res_vld0), 32'd0);
    chk("hs_rdy", 32'(in_rdy0), 32'd1);
  endtask

  initial begin
    rst = 1'b1; co = '0; co_vld = 1'b0; flush = 1'b0; res_rdy = 1'b0;
    #12;
    chk("rst_in_rdy", 32'(in_rdy0), 32'd1);
    chk("rst_vld", 32'(res_vld0), 32'd0);
    chk("rst_cnt", 32'(res_cnt0), 32'd0);
    chk("rst_drop", 32'(drop0), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Full batch
    exp_q.push_back('{par: 4'b1000, pop: 5'd7, cnt: 3'd4});
    sample(4'b0110, 1'b0);
    sample(4'b1111, 1'b0);
    sample(4'b0001, 1'b0);
    chk("full_not_yet", 32'(res_vld0), 32'd0);
    sample(4'b0000, 1'b0);
    chk("full_vld", 32'(res_vld0), 32'd1);
    chk("full_in_rdy", 32'(in_rdy0), 32'd0);
    chk("full_par", 32'(res_par0), 32'b1000);
    chk("full_pop", 32'(res_pop0), 32'd7);
    chk("full_cnt", 32'(res_cnt0), 32'd4);

    // Hold and drop
    sample(4'b1010, 1'b0);
    sample(4'b0101, 1'b1);
    sample(4'b1111, 1'b0);
    chk("hold_drop", 32'(drop0), 32'd3);
    chk("hold_par", 32'(res_par0), 32'b1000);
    chk("hold_cnt", 32'(res_cnt0), 32'd4);
    chk("hold_vld", 32'(res_vld0), 32'd1);
    handshake();

    // Early flush with the flush-cycle sample included
    exp_q.push_back('{par: 4'b1010, pop: 5'd4, cnt: 3'd2});
    sample(4'b1001, 1'b0);
    sample(4'b0011, 1'b1);
    chk("flush_vld", 32'(res_vld0), 32'd1);
    chk("flush_cnt", 32'(res_cnt0), 32'd2);
    chk("flush_par", 32'(res_par0), 32'b1010);

    // Two more drops: wide counter reaches 5, narrow one saturates at 3
    sample(4'b0001, 1'b0);
    sample(4'b0001, 1'b0);
    chk("drop_wide", 32'(drop0), 32'd5);
    chk("drop_sat", 32'(drop1), 32'd3);
    handshake();

    // Idle flush is ignored
    flush = 1'b1; step(); flush = 1'b0; step();
    chk("idle_vld", 32'(res_vld0), 32'd0);
    chk("idle_rdy", 32'(in_rdy0), 32'd1);

    // Async reset mid-batch, then a clean batch
    sample(4'b1111, 1'b0);
    sample(4'b0101, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 32'(res_vld0), 32'd0);
    chk("arst_rdy", 32'(in_rdy0), 32'd1);
    chk("arst_par", 32'(res_par0), 32'd0);
    chk("arst_pop", 32'(res_pop0), 32'd0);
    chk("arst_drop", 32'(drop0), 32'd0);
    chk("arst_drop_d2", 32'(drop1), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back('{par: 4'b1110, pop: 5'd5, cnt: 3'd4});
    sample(4'b0011, 1'b0);
    sample(4'b0100, 1'b0);
    sample(4'b1000, 1'b0);
    sample(4'b0001, 1'b0);
    chk("post_cnt", 32'(res_cnt0), 32'd4);
    chk("post_pop", 32'(res_pop0), 32'd5);
    handshake();

    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
